// File: rtl/misr_response_analyzer_if.sv
// Handshake/bus bundle between the BIST controller side and the MISR analyzer.
// The master drives run control, responses and scan input; the slave is the analyzer.
interface misr_response_analyzer_if #(
  parameter int NBIT = 4,
  parameter int NPAT = 15
);
  localparam int CW = $clog2(NPAT + 1);

  logic            start;
  logic            resp_valid;
  logic [NBIT-1:0] resp_in;
  logic            scan_en;
  logic            scan_in;
  logic            scan_out;
  logic [NBIT-1:0] signature;
  logic            busy;
  logic            done;
  logic            pass;
  logic [CW-1:0]   pat_count;

  modport master (
    output start, resp_valid, resp_in, scan_en, scan_in,
    input  scan_out, signature, busy, done, pass, pat_count
  );

  modport slave (
    input  start, resp_valid, resp_in, scan_en, scan_in,
    output scan_out, signature, busy, done, pass, pat_count
  );
endinterface

// File: rtl/misr_response_analyzer.sv
// Multiple-input signature register that compacts NPAT circuit responses,
// compares the result with a golden signature and exposes the register on a
// serial scan path between runs.
module misr_response_analyzer #(
  parameter int              NBIT   = 4,
  parameter logic [NBIT-1:0] POLY   = 4'b1100,
  parameter logic [NBIT-1:0] SEED   = 4'b0000,
  parameter int              NPAT   = 15,
  parameter logic [NBIT-1:0] GOLDEN = 4'b0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  misr_response_analyzer_if.slave   bus
);
  localparam int CW = $clog2(NPAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  logic [NBIT-1:0] sig;
  logic [CW-1:0]   cnt;
  logic            done_r;
  logic            pass_r;
  logic            fb;
  logic [NBIT-1:0] sig_next;
  logic [NBIT-1:0] sig_shift;

  // Feedback, MISR step and scan shift are all derived from the current register.
  always_comb begin
    fb        = ^(sig & POLY);
    sig_next  = {sig[NBIT-2:0], fb} ^ bus.resp_in;
    sig_shift = {sig[NBIT-2:0], bus.scan_in};
  end

  // Run-control FSM owning the signature, the response counter and the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sig    <= SEED;
      cnt    <= '0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sig   <= SEED;
            cnt   <= '0;
            state <= COMPACT;
          end else if (bus.scan_en) begin
            sig <= sig_shift;
          end
        end
        COMPACT: begin
          // Gaps in resp_valid simply hold; there is no timeout.
          if (bus.resp_valid) begin
            sig <= sig_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(NPAT - 1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          pass_r <= (sig == GOLDEN);
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          // A new start takes priority over scanning the finished signature.
          if (bus.start) begin
            done_r <= 1'b0;
            pass_r <= 1'b0;
            sig    <= SEED;
            cnt    <= '0;
            state  <= COMPACT;
          end else if (bus.scan_en) begin
            sig <= sig_shift;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.scan_out  = sig[NBIT-1];
  assign bus.signature = sig;
  assign bus.busy      = (state == COMPACT) || (state == CHECK);
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.pat_count = cnt;
endmodule
